ibuf_pingpong_sched: RTL and testbench

Tile scheduler for the depthwise input path. It divides the input buffer into two ping-pong halves, letting the DMA loader fill one half while the buffer-interface read sequencer drains the other. Per layer it counts tiles, issues load requests and read-start pulses, tracks the full/empty state of each half, and reports layer completion. It sits between the global controller (configuration), the loader, and the buffer-interface sequencer; its `rd_start` output drives the sequencer's block-start input.

---
 rtl/ibuf_pingpong_sched_if.sv | 29 ++
 rtl/ibuf_pingpong_sched.sv | 151 +++++++++++++++
 tb/tb_ibuf_pingpong_sched.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ibuf_pingpong_sched_if.sv
// Scheduler-side bundle: layer configuration, loader and read-sequencer handshakes, status.
// The master modport is the surrounding system (controller, loader, reader); slave is the scheduler.
interface ibuf_pingpong_sched_if #(
  parameter int NTILE_W = 8,
  parameter int STALL_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [NTILE_W-1:0] cfg_ntile;
  logic               ld_req;
  logic               ld_sel;
  logic               ld_done;
  logic               rd_start;
  logic               rd_sel;
  logic               rd_done;
  logic               layer_done;
  logic               busy;
  logic [STALL_W-1:0] stall_cnt;

  modport master (
    output cfg_valid, cfg_ntile, ld_done, rd_done,
    input  cfg_ready, ld_req, ld_sel, rd_start, rd_sel, layer_done, busy, stall_cnt
  );

  modport slave (
    input  cfg_valid, cfg_ntile, ld_done, rd_done,
    output cfg_ready, ld_req, ld_sel, rd_start, rd_sel, layer_done, busy, stall_cnt
  );
endinterface

// File: rtl/ibuf_pingpong_sched.sv
// Ping-pong input-buffer tile scheduler: the loader fills one half while the reader drains the other,
// counting tiles per layer and reporting layer completion and reader starvation.
module ibuf_pingpong_sched #(
  parameter int NTILE_W = 8,
  parameter int STALL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ibuf_pingpong_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [NTILE_W-1:0] ntile_r;
  logic [NTILE_W-1:0] ld_cnt;
  logic [NTILE_W-1:0] rd_cnt;
  logic [1:0]         full;
  logic [1:0]         full_nxt;
  logic               ld_ptr;
  logic               rd_ptr;
  logic               ld_busy;
  logic               rd_busy;
  logic               ld_gap;
  logic               ld_sel_r;
  logic               rd_sel_r;
  logic               rd_start_r;
  logic               layer_done_r;
  logic [STALL_W-1:0] stall_r;

  logic               cfg_acc;
  logic               in_run;
  logic               last_rd;
  logic               ld_issue;
  logic               ld_fin;
  logic               rd_issue;
  logic               rd_fin;
  logic               stall_hit;

  // FSM next-state logic.
  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_acc) state_nxt = RUN;
      RUN:     if (last_rd) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the reset is synchronous (sampled only on clk), matching the rest of this datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshake decode. Every load/read event is gated by RUN, so pulses in IDLE or DONE are dropped.
  always_comb begin
    cfg_acc   = (state == IDLE) && bus.cfg_valid;
    in_run    = (state == RUN);
    last_rd   = in_run && (rd_cnt == ntile_r);
    ld_issue  = in_run && !ld_busy && !full[ld_ptr] && (ld_cnt < ntile_r) && !ld_gap;
    ld_fin    = in_run && ld_busy && bus.ld_done;
    rd_issue  = in_run && !rd_busy && full[rd_ptr];
    rd_fin    = in_run && rd_busy && bus.rd_done;
    stall_hit = in_run && !rd_busy && !full[rd_ptr] && (rd_cnt < ntile_r);

    // Loader and reader always own different halves, so both updates can land in one edge.
    full_nxt = full;
    if (ld_fin) full_nxt[ld_ptr] = 1'b1;
    if (rd_fin) full_nxt[rd_ptr] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ntile_r      <= '0;
      ld_cnt       <= '0;
      rd_cnt       <= '0;
      full         <= '0;
      ld_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      ld_busy      <= 1'b0;
      rd_busy      <= 1'b0;
      ld_gap       <= 1'b0;
      ld_sel_r     <= 1'b0;
      rd_sel_r     <= 1'b0;
      rd_start_r   <= 1'b0;
      layer_done_r <= 1'b0;
      stall_r      <= '0;
    end else begin
      rd_start_r   <= rd_issue;
      layer_done_r <= last_rd;
      // One dead cycle after each fill keeps ld_req low between consecutive loads.
      ld_gap       <= ld_fin;

      if (cfg_acc) begin
        ntile_r <= bus.cfg_ntile;
        ld_cnt  <= '0;
        rd_cnt  <= '0;
        full    <= '0;
        ld_ptr  <= 1'b0;
        rd_ptr  <= 1'b0;
        ld_busy <= 1'b0;
        rd_busy <= 1'b0;
        stall_r <= '0;
      end else begin
        full <= full_nxt;

        if (ld_issue) begin
          ld_busy  <= 1'b1;
          ld_sel_r <= ld_ptr;
        end
        if (ld_fin) begin
          ld_busy <= 1'b0;
          ld_ptr  <= ~ld_ptr;
          ld_cnt  <= ld_cnt + NTILE_W'(1);
        end

        if (rd_issue) begin
          rd_busy  <= 1'b1;
          rd_sel_r <= rd_ptr;
        end
        if (rd_fin) begin
          rd_busy <= 1'b0;
          rd_ptr  <= ~rd_ptr;
          rd_cnt  <= rd_cnt + NTILE_W'(1);
        end

        if (stall_hit && (stall_r != '1)) stall_r <= stall_r + STALL_W'(1);
      end
    end
  end

  assign bus.cfg_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.ld_req     = ld_busy;
  assign bus.ld_sel     = ld_sel_r;
  assign bus.rd_start   = rd_start_r;
  assign bus.rd_sel     = rd_sel_r;
  assign bus.layer_done = layer_done_r;
  assign bus.stall_cnt  = stall_r;

endmodule

// File: tb/tb_ibuf_pingpong_sched.sv
// Randomized bench for ibuf_pingpong_sched: acts as controller, loader and reader, then checks the
// recorded event times against a per-tile timeline model derived from the scheduling rules.
module tb_ibuf_pingpong_sched;
  localparam int NTILE_W = 8;
  localparam int STALL_W = 16;
  localparam int MAXT    = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   layer_id = 0;
  int   last_exp_stall = 0;

  int ldreq_t  [MAXT];
  int lddone_t [MAXT];
  int rdstart_t[MAXT];
  int rddone_t [MAXT];

  ibuf_pingpong_sched_if #(.NTILE_W(NTILE_W), .STALL_W(STALL_W)) bus ();

  ibuf_pingpong_sched #(.NTILE_W(NTILE_W), .STALL_W(STALL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, " cfg_ready"},  bus.cfg_ready, 1);
    check({pfx, " busy"},       bus.busy, 0);
    check({pfx, " ld_req"},     bus.ld_req, 0);
    check({pfx, " ld_sel"},     bus.ld_sel, 0);
    check({pfx, " rd_start"},   bus.rd_start, 0);
    check({pfx, " rd_sel"},     bus.rd_sel, 0);
    check({pfx, " layer_done"}, bus.layer_done, 0);
    check({pfx, " stall_cnt"},  bus.stall_cnt, 0);
  endtask

  // One layer: drive config, answer loads/reads with random latencies, then compare against the model.
  task automatic run_layer(input int n, input int ld_lo, input int ld_hi,
                           input int rd_lo, input int rd_hi, input bit spur);
    int acc;
    int nld = 0, nrs = 0, nldd = 0, nrdd = 0, nlay = 0;
    int lay_t = -1, rdy_t = -1, ld_due = -1, rd_due = -1;
    int l_t, r_t, f_t, last, exp_stall = 0;
    bit prev_req = 1'b0, fin = 1'b0;
    string lt;
    layer_id++;
    lt = $sformatf("L%0d", layer_id);

    @(negedge clk);
    check({lt, " cfg_ready_pre"}, bus.cfg_ready, 1);
    bus.cfg_valid = 1'b1;
    bus.cfg_ntile = NTILE_W'(n);
    acc = cyc;

    for (int t = 0; t < 3000 && !fin; t++) begin
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      bus.ld_done   = 1'b0;
      bus.rd_done   = 1'b0;

      if (bus.ld_req && !prev_req) begin
        if (nld < MAXT) begin
          ldreq_t[nld] = cyc;
          check($sformatf("%s ld_sel@req%0d", lt, nld), bus.ld_sel, nld % 2);
        end
        nld++;
        ld_due = cyc + int'($urandom_range(ld_hi, ld_lo));
      end
      prev_req = bus.ld_req;

      if (bus.rd_start) begin
        if (nrs < MAXT) begin
          rdstart_t[nrs] = cyc;
          check($sformatf("%s rd_sel@start%0d", lt, nrs), bus.rd_sel, nrs % 2);
        end
        nrs++;
        rd_due = cyc + int'($urandom_range(rd_hi, rd_lo));
      end

      if (bus.layer_done) begin
        nlay++;
        lay_t = cyc;
      end

      if (bus.cfg_ready) begin
        rdy_t = cyc;
        fin   = 1'b1;
      end else begin
        if (cyc == ld_due) begin
          bus.ld_done = 1'b1;
          if (nldd < MAXT) lddone_t[nldd] = cyc;
          nldd++;
          ld_due = -1;
        end else if (spur && !bus.ld_req && ($urandom_range(3, 0) == 0)) begin
          bus.ld_done = 1'b1;
        end

        if (cyc == rd_due) begin
          bus.rd_done = 1'b1;
          if (nrdd < MAXT) rddone_t[nrdd] = cyc;
          nrdd++;
          rd_due = -1;
        end else if (spur && (rd_due < 0) && ($urandom_range(3, 0) == 0)) begin
          bus.rd_done = 1'b1;
        end

        if (spur && ($urandom_range(7, 0) == 0)) begin
          bus.cfg_valid = 1'b1;
          bus.cfg_ntile = NTILE_W'($urandom_range(20, 0));
        end
      end
    end

    check({lt, " finished"},     fin, 1);
    check({lt, " n_ld_req"},     nld, n);
    check({lt, " n_rd_start"},   nrs, n);
    check({lt, " n_layer_done"}, nlay, 1);

    if (fin && nld == n && nrs == n && nldd == n && nrdd == n && n <= MAXT) begin
      for (int i = 0; i < n; i++) begin
        // Load i may issue once the previous fill's gap cycle has passed and its half has been drained.
        l_t = (i == 0) ? acc + 1 : lddone_t[i-1] + 2;
        if (i >= 2 && rddone_t[i-2] + 1 > l_t) l_t = rddone_t[i-2] + 1;
        check($sformatf("%s ld_req_t%0d", lt, i), ldreq_t[i], l_t + 1);
        // Read i is issued once the reader is idle and tile i's half is full; the gap is starvation.
        r_t = (i == 0) ? acc + 1 : rddone_t[i-1] + 1;
        f_t = lddone_t[i] + 1;
        check($sformatf("%s rd_start_t%0d", lt, i), rdstart_t[i], ((r_t > f_t) ? r_t : f_t) + 1);
        if (f_t > r_t) exp_stall += f_t - r_t;
      end
      last = (n == 0) ? acc : rddone_t[n-1];
      check({lt, " layer_done_t"}, lay_t, last + 2);
      check({lt, " cfg_ready_t"},  rdy_t, last + 3);
      check({lt, " stall_cnt"},    bus.stall_cnt, exp_stall);
    end
    last_exp_stall = exp_stall;
  endtask

  // Reader never answers; reset is pulsed once tile 0 is being read and tile 1 sits in the other half.
  task automatic abort_mid_layer();
    int due = -1, nldd = 0, last_d = -1;
    bit prev = 1'b0, seen_rs = 1'b0, hit = 1'b0;
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_ntile = NTILE_W'(4);
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      bus.ld_done   = 1'b0;
      if (bus.ld_req && !prev) due = cyc + 2;
      prev = bus.ld_req;
      if (bus.rd_start) seen_rs = 1'b1;
      if (seen_rs && nldd == 2 && cyc > last_d) begin
        hit = 1'b1;
      end else if (cyc == due) begin
        bus.ld_done = 1'b1;
        nldd++;
        last_d = cyc;
        due = -1;
      end
    end
    check("abort reached", hit, 1);
    check("abort busy_pre", bus.busy, 1);
    check("abort ld_sel_pre", bus.ld_sel, 1);
    check("abort stall_pre", bus.stall_cnt, 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("abort");
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_ntile = '0;
    bus.ld_done   = 1'b0;
    bus.rd_done   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("reset");

    run_layer(0, 1, 1, 1, 1, 1'b0);
    run_layer(1, 5, 5, 10, 10, 1'b0);
    run_layer(4, 2, 2, 20, 20, 1'b0);
    run_layer(3, 30, 30, 3, 3, 1'b0);
    // Latencies 3/4 line up ld_done and rd_done on the same edge for later tiles.
    run_layer(4, 3, 3, 4, 4, 1'b1);

    @(negedge clk);
    bus.rd_done = 1'b1;
    bus.ld_done = 1'b1;
    @(negedge clk);
    bus.rd_done = 1'b0;
    bus.ld_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("idle_pulse cfg_ready", bus.cfg_ready, 1);
      check("idle_pulse rd_start", bus.rd_start, 0);
      check("idle_pulse ld_req", bus.ld_req, 0);
      check("idle_pulse stall_cnt", bus.stall_cnt, last_exp_stall);
      @(negedge clk);
    end

    abort_mid_layer();
    run_layer(2, 1, 4, 1, 4, 1'b0);

    for (int k = 0; k < 8; k++) begin
      run_layer(int'($urandom_range(9, 0)), 1, int'($urandom_range(10, 1)),
                1, int'($urandom_range(10, 1)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
